// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous mon_clock against the local clock.
// Optional duty-cycle window check is compiled in with CLOCK_MONITOR_DUTY_CHECK_EN.
module clock_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int PERIOD_TOL = 1,
  parameter int EXP_HIGH   = 5,
  parameter int HIGH_TOL   = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mon_clock,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_err,
  output logic             duty_err,
  output logic             clk_lost,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] EXP_P = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] P_TOL = CNT_W'(PERIOD_TOL);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, hcnt, hcnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt, pdiff;
  logic             mv_nxt, ferr_nxt, lost_nxt;
  logic             sync1, sync2, sync3;
  logic             rise, fall, timeout, arm_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= mon_clock;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise    = sync2 & ~sync3;
  assign fall    = ~sync2 & sync3;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign timeout = (cnt >= TO_C);
  assign pdiff   = (cnt > EXP_P) ? (cnt - EXP_P) : (EXP_P - cnt);
  assign arm_clr = (state == IDLE) && enable;
  assign busy    = (state != IDLE);

  // enable beats timeout, timeout beats any coincident edge
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    period_nxt = period;
    high_nxt   = high_time;
    mv_nxt     = 1'b0;
    ferr_nxt   = freq_err;
    lost_nxt   = clk_lost;
    if (state == IDLE) begin
      if (enable) begin
        state_nxt = ARM;
        cnt_nxt   = '0;
        ferr_nxt  = 1'b0;
        lost_nxt  = 1'b0;
      end
    end else if (!enable) begin
      state_nxt = IDLE;
    end else if (timeout) begin
      state_nxt = ARM;
      cnt_nxt   = '0;
      lost_nxt  = 1'b1;
    end else begin
      cnt_nxt = cnt_inc;
      case (state)
        ARM: if (rise) begin
          state_nxt = HIGH;
          cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
        HIGH: if (fall) begin
          state_nxt = LOW;
          hcnt_nxt  = cnt;
        end
        LOW: if (rise) begin
          state_nxt  = HIGH;
          period_nxt = cnt;
          high_nxt   = hcnt;
          mv_nxt     = 1'b1;
          cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
          if (pdiff > P_TOL) ferr_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      freq_err   <= 1'b0;
      clk_lost   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hcnt       <= hcnt_nxt;
      period     <= period_nxt;
      high_time  <= high_nxt;
      meas_valid <= mv_nxt;
      freq_err   <= ferr_nxt;
      clk_lost   <= lost_nxt;
    end
  end

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_H = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] H_TOL = CNT_W'(HIGH_TOL);
  logic [CNT_W-1:0] hdiff;

  assign hdiff = (hcnt > EXP_H) ? (hcnt - EXP_H) : (EXP_H - hcnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      duty_err <= 1'b0;
    else if (arm_clr)               duty_err <= 1'b0;
    else if (mv_nxt && hdiff > H_TOL) duty_err <= 1'b1;
  end
`else
  // duty window parameters only matter when the checker is built
  logic unused_duty_cfg;
  assign unused_duty_cfg = (EXP_HIGH != HIGH_TOL) & arm_clr;
  assign duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Random and directed stimulus for clock_monitor, checked every cycle against an
// edge-timestamp model of the measurement rules.
module tb_clock_monitor;
  localparam int CNT_W = 16, EXP_PERIOD = 10, PERIOD_TOL = 1;
  localparam int EXP_HIGH = 5, HIGH_TOL = 1, TIMEOUT = 64;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, mon_clock = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, freq_err, duty_err, clk_lost, busy;

  int total = 0, bad = 0;

  clock_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .PERIOD_TOL(PERIOD_TOL),
                  .EXP_HIGH(EXP_HIGH), .HIGH_TOL(HIGH_TOL), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mon_clock(mon_clock),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .freq_err(freq_err), .duty_err(duty_err), .clk_lost(clk_lost), .busy(busy));

  always #5 clock = ~clock;

  // mon_clock edges land 2 or 7 units past a 10-unit boundary, never on a rising clock edge
  int mon_hi = 50, mon_lo = 50;
  bit mon_run = 1'b0;
  initial begin
    #2;
    forever begin
      if (mon_run) begin
        mon_clock = 1'b1; #(mon_hi);
        mon_clock = 1'b0; #(mon_lo);
      end else begin
        mon_clock = 1'b0; #10;
      end
    end
  end

  // model: sampled pin history, timestamps of counted rise/fall, reference point of the counter
  bit smp_q[$] = '{0, 0, 0, 0};
  int cyc = 0, t_rise = -1, t_fall = -1, t_ref = 0, m_last_mv = -1;
  bit m_active = 0, m_mv = 0, m_ferr = 0, m_derr = 0, m_lost = 0;
  logic [CNT_W-1:0] m_period = '0, m_high = '0;

  always @(posedge clock) begin
    bit r, f;
    int p, h, dp, dh;
    if (reset) begin
      smp_q = '{0, 0, 0, 0};
      m_active = 0; m_mv = 0; m_ferr = 0; m_derr = 0; m_lost = 0;
      m_period = '0; m_high = '0; t_rise = -1; t_fall = -1;
    end else begin
      r = smp_q[1] && !smp_q[2];
      f = !smp_q[1] && smp_q[2];
      m_mv = 0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1; m_ferr = 0; m_derr = 0; m_lost = 0;
          t_rise = -1; t_fall = -1; t_ref = cyc + 1;
        end
      end else if (!enable) begin
        m_active = 0;
      end else if (cyc - t_ref >= TIMEOUT) begin
        m_lost = 1; t_rise = -1; t_fall = -1; t_ref = cyc + 1;
      end else if (t_rise < 0) begin
        if (r) begin t_rise = cyc; t_ref = cyc; end
      end else if (t_fall < 0) begin
        if (f) t_fall = cyc;
      end else if (r) begin
        p = cyc - t_rise;
        h = t_fall - t_rise;
        m_period = CNT_W'(p);
        m_high = CNT_W'(h);
        m_mv = 1;
        m_last_mv = cyc;
        dp = (p > EXP_PERIOD) ? p - EXP_PERIOD : EXP_PERIOD - p;
        dh = (h > EXP_HIGH) ? h - EXP_HIGH : EXP_HIGH - h;
        if (dp > PERIOD_TOL) m_ferr = 1;
        if (DUTY_ON && dh > HIGH_TOL) m_derr = 1;
        t_rise = cyc; t_fall = -1; t_ref = cyc;
      end
      smp_q.push_front(mon_clock);
      void'(smp_q.pop_back());
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (!reset) begin
      total++;
      if ({period, high_time, meas_valid, freq_err, duty_err, clk_lost, busy} !==
          {m_period, m_high, m_mv, m_ferr, m_derr, m_lost, m_active}) begin
        bad++;
        $display("FAIL cycle_check cyc=%0d got per=%0d hi=%0d mv=%b fe=%b de=%b lost=%b busy=%b want per=%0d hi=%0d mv=%b fe=%b de=%b lost=%b busy=%b",
                 cyc, period, high_time, meas_valid, freq_err, duty_err, clk_lost, busy,
                 m_period, m_high, m_mv, m_ferr, m_derr, m_lost, m_active);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_mv(input string name, input int count);
    for (int k = 0; k < count; k++) begin
      int n = 0;
      do begin @(negedge clock); n++; end while (meas_valid !== 1'b1 && n < 300);
      check(name, 32'(meas_valid), 32'd1);
    end
  endtask

  initial begin
    int n, lost_cyc;
    repeat (3) @(negedge clock);
    check("rst_period", 32'(period), 32'd0);
    check("rst_high", 32'(high_time), 32'd0);
    check("rst_flags", 32'({meas_valid, freq_err, duty_err, clk_lost, busy}), 32'd0);

    // nominal 100-unit clock at 50% duty
    reset = 1'b0; enable = 1'b1; mon_run = 1'b1;
    wait_mv("mv_nominal", 4);
    check("nom_period", 32'(period), 32'd10);
    check("nom_high", 32'(high_time), 32'd5);
    check("nom_flags", 32'({freq_err, duty_err, clk_lost}), 32'd0);

    // drop enable right after a measurement (state HIGH)
    enable = 1'b0;
    @(negedge clock);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_hold", 32'(period), 32'd10);

    // slow clock, 130 units
    mon_hi = 65; mon_lo = 65; enable = 1'b1;
    wait_mv("mv_slow", 4);
    check("slow_period", 32'(period), 32'd13);
    check("slow_ferr", 32'(freq_err), 32'd1);

    // 80% duty
    enable = 1'b0; @(negedge clock);
    mon_hi = 80; mon_lo = 20; enable = 1'b1;
    wait_mv("mv_duty", 4);
    check("duty_high", 32'(high_time), 32'd8);
    check("duty_period", 32'(period), 32'd10);
    check("duty_derr", 32'(duty_err), 32'(DUTY_ON));

    // stop the clock low after lock
    enable = 1'b0; @(negedge clock);
    mon_hi = 50; mon_lo = 50; enable = 1'b1;
    wait_mv("mv_prelost", 3);
    mon_run = 1'b0;
    n = 0;
    while (clk_lost !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    lost_cyc = cyc - 1;
    check("lost_seen", 32'(clk_lost), 32'd1);
    check("lost_delay", 32'(lost_cyc - m_last_mv), 32'd64);
    check("lost_busy", 32'(busy), 32'd1);

    // async reset in the LOW phase
    mon_run = 1'b1;
    wait_mv("mv_prerst", 3);
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_meas", 32'({period, high_time}), 32'd0);
    check("arst_flags", 32'({meas_valid, freq_err, duty_err, clk_lost, busy}), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int s = 0; s < 40; s++) begin
      mon_hi = 5 * int'($urandom_range(2, 16));
      mon_lo = 5 * int'($urandom_range(2, 16));
      if ($urandom_range(0, 3) == 0) begin mon_hi = 50; mon_lo = 50; end
      mon_run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        enable = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
      repeat ($urandom_range(20, 120)) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all cycle counters and measurement outputs.
REQ-002 SHALL have parameter EXP_PERIOD, default 10: expected mon_clock period in clock cycles.
REQ-003 SHALL have parameter PERIOD_TOL, default 1: allowed period deviation in cycles, inclusive.
REQ-004 SHALL have parameter EXP_HIGH, default 5: expected mon_clock high time in clock cycles.
REQ-005 SHALL have parameter HIGH_TOL, default 1: allowed high-time deviation in cycles, inclusive.
REQ-006 SHALL have parameter TIMEOUT, default 64: cycles without a mon_clock edge before loss is declared; valid range 2..2^CNT_W-1.
REQ-007 SHALL have port clock, input, 1: reference sampling clock; all state on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1: monitor run enable, synchronous to clock.
REQ-010 SHALL have port mon_clock, input, 1: monitored clock from the upstream clock_generator, asynchronous to clock.
REQ-011 SHALL have port period, output, CNT_W: last measured rise-to-rise count.
REQ-012 SHALL have port high_time, output, CNT_W: last measured rise-to-fall count.
REQ-013 SHALL have port meas_valid, output, 1: single-cycle pulse when period and high_time update.
REQ-014 SHALL have port freq_err, output, 1: sticky period-out-of-window flag.
REQ-015 SHALL have port duty_err, output, 1: sticky high-time-out-of-window flag.
REQ-016 SHALL have port clk_lost, output, 1: sticky timeout flag.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL pass mon_clock through a 2-flop synchronizer plus a third history flop; a rise is sync2 & ~sync3 and a fall is ~sync2 & sync3, so an edge is detected 2-3 cycles after the pin toggles.
REQ-019 SHALL implement states IDLE, ARM, HIGH and LOW.
REQ-020 IDLE SHALL go to ARM when enable=1, clearing freq_err, duty_err and clk_lost and loading cnt=0.
REQ-021 ARM SHALL go to HIGH on a rise, loading cnt=1; falls are ignored in ARM.
REQ-022 In HIGH and LOW, cnt SHALL increment by 1 per cycle with no edge, saturating at 2^CNT_W-1.
REQ-023 HIGH SHALL go to LOW on a fall, latching hcnt=cnt at that cycle.
REQ-024 LOW SHALL go to HIGH on a rise, loading period=cnt and high_time=hcnt, pulsing meas_valid for one cycle and reloading cnt=1 in the same cycle.
REQ-025 freq_err SHALL set on the meas_valid cycle if |cnt-EXP_PERIOD| > PERIOD_TOL; the comparison is unsigned, with no wrap.
REQ-026 If cnt reaches TIMEOUT in ARM, HIGH or LOW, the block SHALL set clk_lost, go to ARM with cnt=0, and not assert meas_valid.
REQ-027 In ARM, cnt SHALL increment every cycle so that timeout applies there too.
REQ-028 If enable=0 in any non-IDLE state, the block SHALL go to IDLE next cycle with no meas_valid; period, high_time and the sticky flags SHALL hold.
REQ-029 When enable falls and a rise occur in the same cycle, enable SHALL take priority.
REQ-030 Timeout SHALL take priority over a coincident edge.

Reset
REQ-031 Reset SHALL force state=IDLE and clear period, high_time, meas_valid, freq_err, duty_err, clk_lost, busy, cnt, hcnt and all synchronizer flops to 0, asynchronously.
REQ-032 Reset deassertion mid-measurement SHALL restart from IDLE; no stale measurement SHALL be reported.

Configuration
REQ-033 With macro CLOCK_MONITOR_DUTY_CHECK_EN defined, duty_err SHALL set on the meas_valid cycle if |hcnt-EXP_HIGH| > HIGH_TOL.
REQ-034 Without CLOCK_MONITOR_DUTY_CHECK_EN, duty_err SHALL be constant 0 and the comparator SHALL be absent; high_time is still reported.

Verification
REQ-035 clock 10 ns, mon_clock 100 ns at 50% duty, enable=1 -> from the second rise, meas_valid every 10 cycles with period=10, high_time=5, all error flags 0.
REQ-036 mon_clock 130 ns at 50% duty -> period=13 and freq_err=1 after the first meas_valid, and freq_err stays 1 while enable=1.
REQ-037 mon_clock 100 ns at 80% duty, macro defined -> high_time=8 and duty_err=1; macro undefined -> high_time=8 and duty_err=0.
REQ-038 mon_clock stopped low after lock -> clk_lost=1 exactly 64 cycles after the last rise detection, state=ARM, no meas_valid.
REQ-039 enable dropped mid-HIGH, then re-raised -> busy=0 the next cycle, outputs hold, flags clear on re-arm, and the first new meas_valid comes after two rises.
REQ-040 reset asserted mid-LOW -> all outputs 0 immediately, without waiting for a clock edge.
